// File: rtl/mul_stream_adapter.sv
// mul_stream_adapter: valid/ready front-end and result collector for a start/done bit-serial multiplier.
// Operand pairs queue in a small FIFO; each result is captured into a single output slot with its tag.
`default_nettype none

module mul_stream_adapter #(
  parameter int N     = 5,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_a,
  input  logic [N-1:0]       in_x,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N-1:0]     out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               mul_start,
  output logic [N-1:0]       mul_a,
  output logic [N-1:0]       mul_x,
  input  logic [2*N-1:0]     mul_p,
  input  logic               mul_done,
  output logic               busy,
  output logic [15:0]        ops_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2*N + TAG_W;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [EW-1:0]    head;
  logic [TAG_W-1:0] pend_tag;
  logic             empty, full, push, pop, capture, drain;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign mul_a    = head[EW-1 -: N];
  assign mul_x    = head[TAG_W +: N];
  assign drain    = out_valid && out_ready;
  assign busy     = !empty || (state != IDLE) || out_valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_a, in_x, in_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = ISSUE;
      end
      ISSUE: begin
        mul_start = 1'b1;
        pop       = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // mul_done is a level, so holding here under backpressure loses nothing.
        if (mul_done && (!out_valid || out_ready)) begin
          capture   = 1'b1;
          state_nxt = empty ? IDLE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_tag  <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
      ops_done  <= '0;
    end else begin
      if (pop) pend_tag <= head[TAG_W-1:0];
      if (capture) begin
        out_p     <= mul_p;
        out_tag   <= pend_tag;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain) ops_done <= ops_done + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_stream_adapter.sv
// tb_mul_stream_adapter: randomized and directed bench with a behavioural multiplier and a
// product/tag reference queue derived from signed arithmetic.
`default_nettype none

module tb_mul_stream_adapter;

  localparam int N     = 5;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_a = '0;
  logic [N-1:0]     in_x = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*N-1:0]   out_p;
  logic [TAG_W-1:0] out_tag;
  logic             mul_start;
  logic [N-1:0]     mul_a, mul_x;
  logic [2*N-1:0]   mul_p;
  logic             mul_done;
  logic             busy;
  logic [15:0]      ops_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int full_seen = 0;

  logic [2*N+TAG_W-1:0] exp_q[$];
  logic [2*N+TAG_W-1:0] got_q[$];
  int                   start_q[$];

  mul_stream_adapter #(.N(N), .DEPTH(2), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag),
    .mul_start(mul_start), .mul_a(mul_a), .mul_x(mul_x), .mul_p(mul_p), .mul_done(mul_done),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] x);
    int sa, sx, r;
    sa = $signed(a);
    sx = $signed(x);
    r  = sa * sx;
    return r[2*N-1:0];
  endfunction

  // Behavioural multiplier: done rises N+1 cycles after the start cycle and clears on start.
  logic [4:0]     m_cnt;
  logic [2*N-1:0] m_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_done <= 1'b0; mul_p <= '0; m_cnt <= '0; m_res <= '0;
    end else if (mul_start) begin
      mul_done <= 1'b0; m_cnt <= 5'(N); m_res <= prod(mul_a, mul_x);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 5'd1;
      if (m_cnt == 5'd1) begin
        mul_done <= 1'b1; mul_p <= m_res;
      end
    end
  end

  // Observers sample 2 time units after the falling edge, after stimulus has settled.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (out_valid && out_ready) got_q.push_back({out_p, out_tag});
      if (mul_start) start_q.push_back(cyc);
    end
  end

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] x, input logic [TAG_W-1:0] t,
                      output int acc_cyc);
    int g = 0;
    in_valid = 1'b1; in_a = a; in_x = x; in_tag = t;
    while (!in_ready && g < 100) begin
      full_seen++;
      @(negedge clk);
      g++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
    end else begin
      exp_q.push_back({prod(a, x), t});
    end
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic wait_got(input int n, input int limit);
    int g = 0;
    while (got_q.size() < n && g < limit) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 7;
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got=%b req=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b req=0", out_valid); end
    if (out_p !== '0)       begin bad++; $display("FAIL rst_out_p got=%h req=0", out_p); end
    if (out_tag !== '0)     begin bad++; $display("FAIL rst_out_tag got=%h req=0", out_tag); end
    if (mul_start !== 1'b0) begin bad++; $display("FAIL rst_mul_start got=%b req=0", mul_start); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b req=0", busy); end
    if (ops_done !== 16'd0) begin bad++; $display("FAIL rst_ops_done got=%0d req=0", ops_done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int c0, g = 0;
    out_ready = 1'b0;
    push(5'b11101, 5'b00111, 4'd3, c0);
    in_valid = 1'b0;
    while (!out_valid && g < 40) begin @(negedge clk); g++; end
    total += 3;
    if (cyc - c0 != 9)     begin bad++; $display("FAIL single_latency got=%0d req=9", cyc - c0); end
    if (out_p !== 10'h3EB) begin bad++; $display("FAIL single_p got=%h req=3eb", out_p); end
    if (out_tag !== 4'd3)  begin bad++; $display("FAIL single_tag got=%0d req=3", out_tag); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total += 2;
    if (ops_done !== 16'd1) begin bad++; $display("FAIL single_ops got=%0d req=1", ops_done); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b req=0", out_valid); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_corners();
    logic [N-1:0] av[4];
    logic [N-1:0] xv[4];
    int c;
    av = '{5'b10000, 5'b10000, 5'b00000, 5'b11111};
    xv = '{5'b10000, 5'b01111, 5'b11111, 5'b11111};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(av[i], xv[i], TAG_W'(4 + i), c);
    in_valid = 1'b0;
    wait_got(4, 200);
    total++;
    if (got_q.size() != 4) begin bad++; $display("FAIL corners_count got=%0d req=4", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL corners_res%0d got=%h req=%h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_burst();
    int c;
    out_ready = 1'b1;
    full_seen = 0;
    start_q.delete();
    for (int i = 0; i < 4; i++) push(N'($urandom), N'($urandom), TAG_W'(i), c);
    in_valid = 1'b0;
    wait_got(4, 200);
    total += 2;
    if (full_seen == 0) begin bad++; $display("FAIL burst_full got_lowcycles=%0d req>0", full_seen); end
    if (start_q.size() != 4) begin bad++; $display("FAIL burst_starts got=%0d req=4", start_q.size()); end
    for (int i = 1; i < start_q.size(); i++) begin
      total++;
      if (start_q[i] - start_q[i-1] != 7) begin
        bad++; $display("FAIL burst_spacing%0d got=%0d req=7", i, start_q[i] - start_q[i-1]);
      end
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL burst_res%0d got=%h req=%h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    int c, g = 0, hold_bad = 0;
    logic [2*N+TAG_W-1:0] e0, e1;
    out_ready = 1'b0;
    start_q.delete();
    push(5'd1, 5'b11010, 4'd8, c);
    push(5'b10011, 5'd9, 4'd9, c);
    in_valid = 1'b0;
    e0 = exp_q[0]; e1 = exp_q[1];
    while (!out_valid && g < 40) begin @(negedge clk); g++; end
    repeat (15) begin
      if (!out_valid || {out_p, out_tag} !== e0) hold_bad++;
      @(negedge clk);
    end
    total += 3;
    if (hold_bad != 0)       begin bad++; $display("FAIL bp_hold got_badcycles=%0d req=0", hold_bad); end
    if (start_q.size() != 2) begin bad++; $display("FAIL bp_starts got=%0d req=2", start_q.size()); end
    if (busy !== 1'b1)       begin bad++; $display("FAIL bp_busy got=%b req=1", busy); end
    out_ready = 1'b1;
    @(negedge clk);
    total += 2;
    if (out_valid !== 1'b1)       begin bad++; $display("FAIL bp_second_valid got=%b req=1", out_valid); end
    if ({out_p, out_tag} !== e1) begin bad++; $display("FAIL bp_second got=%h req=%h", {out_p, out_tag}, e1); end
    @(negedge clk);
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b0)  begin bad++; $display("FAIL bp_empty got=%b req=0", out_valid); end
    if (got_q.size() != 2)   begin bad++; $display("FAIL bp_count got=%0d req=2", got_q.size()); end
    if (start_q.size() != 2) begin bad++; $display("FAIL bp_extra_start got=%0d req=2", start_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_res%0d got=%h req=%h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    int sent = 0, g = 0;
    logic acc;
    logic [15:0] ops0;
    ops0 = ops_done;
    in_valid = 1'b0;
    while ((sent < 20 || got_q.size() < exp_q.size()) && g < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 20 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1; in_a = N'($urandom); in_x = N'($urandom); in_tag = TAG_W'($urandom);
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back({prod(in_a, in_x), in_tag});
        sent++;
      end
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      g++;
    end
    out_ready = 1'b0;
    @(negedge clk);
    total += 2;
    if (got_q.size() != 20) begin bad++; $display("FAIL rand_count got=%0d req=20", got_q.size()); end
    if (ops_done !== 16'(ops0 + 16'd20)) begin
      bad++; $display("FAIL rand_ops got=%0d req=%0d", ops_done, 16'(ops0 + 16'd20));
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_res%0d got=%h req=%h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midop();
    int c0, c, g = 0, seen = 0;
    out_ready = 1'b1;
    push(5'd6, 5'd7, 4'd1, c0);
    push(5'd2, 5'd3, 4'd2, c);
    in_valid = 1'b0;
    while (cyc - c0 < 5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total += 6;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got=%b req=0", out_valid); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL mrst_busy got=%b req=0", busy); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL mrst_in_ready got=%b req=1", in_ready); end
    if (mul_start !== 1'b0) begin bad++; $display("FAIL mrst_start got=%b req=0", mul_start); end
    if (ops_done !== 16'd0) begin bad++; $display("FAIL mrst_ops got=%0d req=0", ops_done); end
    if ({out_p, out_tag} !== '0) begin bad++; $display("FAIL mrst_out got=%h req=0", {out_p, out_tag}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); got_q.delete();
    repeat (20) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    total += 2;
    if (seen != 0)     begin bad++; $display("FAIL mrst_ghost got=%0d req=0", seen); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mrst_idle_busy got=%b req=0", busy); end
    out_ready = 1'b0;
    push(5'b11000, 5'd5, 4'd6, c0);
    in_valid = 1'b0;
    while (!out_valid && g < 40) begin @(negedge clk); g++; end
    total += 2;
    if (cyc - c0 != 9) begin bad++; $display("FAIL mrst_latency got=%0d req=9", cyc - c0); end
    if ({out_p, out_tag} !== exp_q[0]) begin
      bad++; $display("FAIL mrst_result got=%h req=%h", {out_p, out_tag}, exp_q[0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_wrap();
    int c;
    out_ready = 1'b1;
    force dut.ops_done = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done;
    @(negedge clk);
    total++;
    if (ops_done !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h req=ffff", ops_done); end
    push(5'd3, 5'd3, 4'd0, c);
    in_valid = 1'b0;
    wait_got(1, 40);
    total++;
    if (ops_done !== 16'd0) begin bad++; $display("FAIL wrap_ops got=%h req=0", ops_done); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_burst();
    test_backpressure();
    test_random();
    test_reset_midop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
